// File: rtl/fir_pkg.sv
// Shared definitions for the parametrised FIR filter: load/run state encoding,
// width helpers and the shift-and-saturate output function.
package fir_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } fir_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Accumulator wide enough that a full sum of TAPS maximal products cannot overflow.
  function automatic int unsigned acc_width(input int unsigned dw,
                                            input int unsigned cw,
                                            input int unsigned taps);
    return dw + cw + clog2(taps);
  endfunction

  function automatic logic [63:0] shift_sat(input logic [63:0]  acc,
                                            input int unsigned  shift,
                                            input int unsigned  out_w);
    logic [63:0] s;
    logic [63:0] lim;
    s   = acc >> shift;
    lim = (out_w >= 64) ? '1 : ((64'd1 << out_w) - 64'd1);
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Coefficient load controller: LOAD/RUN state machine, write index and the
// coefficient register file shared with the filter datapath.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           coef_valid_i,
  input  logic [COEF_W-1:0]              coef_i,
  input  logic                           coef_reload_i,
  output logic                           coef_ready_o,
  output logic                           run_o,
  output logic                           flush_o,
  output logic [TAPS-1:0][COEF_W-1:0]    coef_o
);

  localparam int unsigned       IDX_W    = (clog2(TAPS) < 1) ? 1 : clog2(TAPS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TAPS - 1);

  fir_state_e                   state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [IDX_W-1:0]             idx_cur;
  logic [TAPS-1:0][COEF_W-1:0]  coef_q, coef_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    coef_d  = coef_q;
    idx_cur = idx_q;
    flush_o = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        // A reload during LOAD restarts at h[0]; a coefficient in the same cycle lands there.
        if (coef_reload_i) idx_cur = '0;
        idx_d = idx_cur;
        if (coef_valid_i) begin
          coef_d[idx_cur] = coef_i;
          if (idx_cur == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_RUN;
          end else begin
            idx_d = idx_cur + IDX_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (coef_reload_i) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          flush_o = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      coef_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      coef_q  <= coef_d;
    end
  end

  assign coef_ready_o = (state_q == ST_LOAD);
  assign run_o        = (state_q == ST_RUN);
  assign coef_o       = coef_q;

endmodule

// File: rtl/fir_filter_param.sv
// Parametrised pipelined direct-form FIR: delay line, registered product stage,
// then sum/shift/saturate into the held output with a one-cycle valid pulse.
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned SHIFT  = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              coef_valid_i,
  input  logic [COEF_W-1:0] coef_i,
  input  logic              coef_reload_i,
  output logic              coef_ready_o,
  input  logic              x_valid_i,
  input  logic [DATA_W-1:0] x_i,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_o
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

  logic                         run;
  logic                         flush;
  logic                         accept;
  logic [TAPS-1:0][COEF_W-1:0]  coef;

  logic [TAPS-1:0][DATA_W-1:0]  dline_q, dline_d;
  logic                         sample_valid_q, sample_valid_d;
  logic [TAPS-1:0][PROD_W-1:0]  prod_q, prod_d;
  logic                         prod_valid_q, prod_valid_d;
  logic [ACC_W-1:0]             acc;
  logic                         y_valid_q, y_valid_d;
  logic [DATA_W-1:0]            y_q, y_d;

  fir_coef_loader #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_loader (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .coef_valid_i  (coef_valid_i),
    .coef_i        (coef_i),
    .coef_reload_i (coef_reload_i),
    .coef_ready_o  (coef_ready_o),
    .run_o         (run),
    .flush_o       (flush),
    .coef_o        (coef)
  );

  // A reload cycle never accepts a sample, even if x_valid_i is high.
  assign accept = run && x_valid_i && !coef_reload_i;

  always_comb begin
    dline_d = dline_q;
    if (flush) begin
      dline_d = '0;
    end else if (accept) begin
      dline_d[0] = x_i;
      for (int unsigned k = 1; k < TAPS; k++) begin
        dline_d[k] = dline_q[k-1];
      end
    end
    sample_valid_d = accept;
  end

  always_comb begin
    prod_d = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      prod_d[k] = PROD_W'(dline_q[k]) * PROD_W'(coef[k]);
    end
    prod_valid_d = sample_valid_q && !flush;
  end

  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      acc = acc + ACC_W'(prod_q[k]);
    end
    // In-flight results are dropped on reload; y_o keeps its last value.
    y_valid_d = prod_valid_q && !flush;
    y_d       = y_valid_d ? DATA_W'(shift_sat(64'(acc), SHIFT, DATA_W)) : y_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dline_q        <= '0;
      sample_valid_q <= 1'b0;
      prod_q         <= '0;
      prod_valid_q   <= 1'b0;
      y_valid_q      <= 1'b0;
      y_q            <= '0;
    end else begin
      dline_q        <= dline_d;
      sample_valid_q <= sample_valid_d;
      prod_q         <= prod_d;
      prod_valid_q   <= prod_valid_d;
      y_valid_q      <= y_valid_d;
      y_q            <= y_d;
    end
  end

  assign y_valid_o = y_valid_q;
  assign y_o       = y_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param: two instances (SHIFT=0 and SHIFT=4) share
// one stimulus stream; expected outputs are hand-computed per cycle.
module tb_fir_filter_param;

  logic       clk;
  logic       reset_i;
  logic       coef_valid_i;
  logic [7:0] coef_i;
  logic       coef_reload_i;
  logic       x_valid_i;
  logic [7:0] x_i;

  logic       rdy0, yv0;
  logic [7:0] y0;
  logic       rdy4, yv4;
  logic [7:0] y4;

  int n_vec;
  int n_bad;

  logic [7:0] hold0, hold4;

  typedef struct {
    logic       xv;
    logic [7:0] x;
    logic       ev;
    logic [7:0] ey0;
    logic [7:0] ey4;
  } vec_t;

  vec_t tbl[$];

  fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(4), .SHIFT(0)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .coef_valid_i(coef_valid_i), .coef_i(coef_i),
    .coef_reload_i(coef_reload_i), .coef_ready_o(rdy0), .x_valid_i(x_valid_i),
    .x_i(x_i), .y_valid_o(yv0), .y_o(y0)
  );

  fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(4), .SHIFT(4)) dut4 (
    .clk_i(clk), .reset_i(reset_i), .coef_valid_i(coef_valid_i), .coef_i(coef_i),
    .coef_reload_i(coef_reload_i), .coef_ready_o(rdy4), .x_valid_i(x_valid_i),
    .x_i(x_i), .y_valid_o(yv4), .y_o(y4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic xv, input logic [7:0] x, input logic ev,
                     input logic [7:0] ey0, input logic [7:0] ey4);
    vec_t v;
    v.xv = xv; v.x = x; v.ev = ev; v.ey0 = ey0; v.ey4 = ey4;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      x_valid_i = tbl[i].xv;
      x_i       = tbl[i].x;
      tick();
      chk($sformatf("%s[%0d].yv0", name, i), {15'd0, yv0}, {15'd0, tbl[i].ev});
      chk($sformatf("%s[%0d].yv4", name, i), {15'd0, yv4}, {15'd0, tbl[i].ev});
      if (tbl[i].ev) begin
        hold0 = tbl[i].ey0;
        hold4 = tbl[i].ey4;
      end
      chk($sformatf("%s[%0d].y0", name, i), {8'd0, y0}, {8'd0, hold0});
      chk($sformatf("%s[%0d].y4", name, i), {8'd0, y4}, {8'd0, hold4});
    end
    x_valid_i = 1'b0;
    tbl.delete();
  endtask

  task automatic load4(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2,
                       input logic [7:0] h3, input logic xv, input logic [7:0] xval);
    logic [7:0] h [4];
    h = '{h0, h1, h2, h3};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("load[%0d].ready", i), {15'd0, rdy0}, 16'd1);
      coef_valid_i = 1'b1;
      coef_i       = h[i];
      x_valid_i    = xv;
      x_i          = xval;
      tick();
      chk($sformatf("load[%0d].yv0", i), {15'd0, yv0}, 16'd0);
    end
    coef_valid_i = 1'b0;
    x_valid_i    = 1'b0;
    chk("load.ready_low0", {15'd0, rdy0}, 16'd0);
    chk("load.ready_low4", {15'd0, rdy4}, 16'd0);
  endtask

  task automatic impulse10_table();
    add(1'b1, 8'h10, 1'b0, 8'h00, 8'h00);
    add(1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    add(1'b1, 8'h00, 1'b1, 8'h10, 8'h01);
    add(1'b1, 8'h00, 1'b1, 8'h20, 8'h02);
    add(1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
    add(1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
    add(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    hold0 = 8'h00;
    hold4 = 8'h00;
    coef_valid_i  = 1'b0;
    coef_i        = 8'h00;
    coef_reload_i = 1'b0;
    x_valid_i     = 1'b0;
    x_i           = 8'h00;

    reset_i = 1'b1;
    #2;
    chk("rst.ready", {15'd0, rdy0}, 16'd1);
    chk("rst.yv", {15'd0, yv0}, 16'd0);
    chk("rst.y", {8'd0, y0}, 16'd0);
    @(negedge clk);
    reset_i = 1'b0;

    // Impulse 0x10 through h={1,2,0,0}
    load4(8'd1, 8'd2, 8'd0, 8'd0, 1'b0, 8'h00);
    impulse10_table();
    run_table("imp10");

    // Impulse 0xFF: second tap saturates
    add(1'b1, 8'hFF, 1'b0, 8'h00, 8'h00);
    add(1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    add(1'b1, 8'h00, 1'b1, 8'hFF, 8'h0F);
    add(1'b0, 8'h00, 1'b1, 8'hFF, 8'h1F);
    add(1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
    add(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    run_table("impFF");

    // Reload from RUN, then h={4,4,4,4} with constant 0x20
    coef_reload_i = 1'b1;
    tick();
    coef_reload_i = 1'b0;
    chk("reload1.ready", {15'd0, rdy0}, 16'd1);
    load4(8'd4, 8'd4, 8'd4, 8'd4, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 1:    add(1'b1, 8'h20, 1'b0, 8'h00, 8'h00);
        2:       add(1'b1, 8'h20, 1'b1, 8'h80, 8'h08);
        3:       add(1'b1, 8'h20, 1'b1, 8'hFF, 8'h10);
        4:       add(1'b1, 8'h20, 1'b1, 8'hFF, 8'h18);
        default: add(1'b1, 8'h20, 1'b1, 8'hFF, 8'h20);
      endcase
    end
    add(1'b0, 8'h00, 1'b1, 8'hFF, 8'h20);
    add(1'b0, 8'h00, 1'b1, 8'hFF, 8'h20);
    add(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    run_table("const20");

    // Samples offered on the reload cycle and during LOAD must be ignored
    coef_reload_i = 1'b1;
    x_valid_i     = 1'b1;
    x_i           = 8'h77;
    tick();
    coef_reload_i = 1'b0;
    x_valid_i     = 1'b0;
    chk("reload2.ready", {15'd0, rdy0}, 16'd1);
    chk("reload2.yv", {15'd0, yv0}, 16'd0);
    load4(8'd1, 8'd2, 8'd0, 8'd0, 1'b1, 8'h55);
    impulse10_table();
    run_table("clean10");

    // Reload with two samples in flight: neither may emerge
    x_valid_i = 1'b1; x_i = 8'h40;
    tick();
    chk("flight.c0.yv", {15'd0, yv0}, 16'd0);
    x_i = 8'h41;
    tick();
    chk("flight.c1.yv", {15'd0, yv0}, 16'd0);
    x_i = 8'h42;
    coef_reload_i = 1'b1;
    tick();
    coef_reload_i = 1'b0;
    x_valid_i     = 1'b0;
    chk("flight.c2.yv", {15'd0, yv0}, 16'd0);
    chk("flight.c2.yv4", {15'd0, yv4}, 16'd0);
    chk("flight.c2.ready", {15'd0, rdy0}, 16'd1);
    tick();
    chk("flight.c3.yv", {15'd0, yv0}, 16'd0);
    chk("flight.c3.y", {8'd0, y0}, {8'd0, hold0});

    // Partial load, then reload in LOAD together with a write to h[0]
    coef_valid_i = 1'b1; coef_i = 8'h09;
    tick();
    tick();
    coef_reload_i = 1'b1; coef_i = 8'h00;
    tick();
    coef_reload_i = 1'b0;
    chk("ldreload.ready", {15'd0, rdy0}, 16'd1);
    coef_i = 8'h01;
    tick();
    coef_i = 8'h00;
    tick();
    chk("ldreload.ready_pre", {15'd0, rdy0}, 16'd1);
    tick();
    coef_valid_i = 1'b0;
    chk("ldreload.ready_low", {15'd0, rdy0}, 16'd0);
    add(1'b1, 8'h33, 1'b0, 8'h00, 8'h00);
    add(1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    add(1'b1, 8'h00, 1'b1, 8'h00, 8'h00);
    add(1'b0, 8'h00, 1'b1, 8'h33, 8'h03);
    add(1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
    add(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    run_table("imp33");

    // Asynchronous reset mid-stream
    x_valid_i = 1'b1; x_i = 8'h50;
    tick();
    tick();
    tick();
    tick();
    chk("async.pre.yv", {15'd0, yv0}, 16'd1);
    chk("async.pre.y", {8'd0, y0}, 16'h0050);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async.yv", {15'd0, yv0}, 16'd0);
    chk("async.y", {8'd0, y0}, 16'd0);
    chk("async.ready", {15'd0, rdy0}, 16'd1);
    chk("async.y4", {8'd0, y4}, 16'd0);
    x_valid_i = 1'b0;
    hold0 = 8'h00;
    hold4 = 8'h00;
    @(negedge clk);
    reset_i = 1'b0;
    load4(8'd1, 8'd2, 8'd0, 8'd0, 1'b0, 8'h00);
    impulse10_table();
    run_table("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
